univ_shift_reg: RTL

- Parametrised universal shift register. It is the next-generation storage element after the D latch/flip-flop cells.
- Supports parallel load and burst shifts of a programmable count in either direction, with serial in/out.
- Exposes busy/done status so a controller can sequence serial transfers.
- Intended as the common serialiser/deserialiser building block for later designs.

---
 rtl/univ_shift_reg_pkg.sv | 13 +
 rtl/univ_shift_reg.sv | 104 ++++++++++
 2 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: burst FSM states and direction codes.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, programmable-length shift bursts with serial in/out.
// Define UNIV_SHIFT_REG_ROTATE_EN to let a burst captured with rot=1 rotate instead of shifting in sin.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             sin,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem;
  logic             dir_r;
  logic             rot_eff;

  // Returns {bit leaving the register, next register value} for one step.
  function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] cur,
                                             input logic             left,
                                             input logic             rotate,
                                             input logic             s);
    logic out_bit;
    logic in_bit;
    out_bit = (left == DIR_LEFT) ? cur[WIDTH-1] : cur[0];
    in_bit  = rotate ? out_bit : s;
    if (left == DIR_LEFT) return {out_bit, cur[WIDTH-2:0], in_bit};
    else                  return {out_bit, in_bit, cur[WIDTH-1:1]};
  endfunction

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  logic rot_r;

  always_ff @(posedge clk) begin
    if (rst)
      rot_r <= 1'b0;
    else if (state == IDLE && !load && start && shift_cnt != '0)
      rot_r <= rot;
  end

  assign rot_eff = rot_r;
`else
  logic unused_rot;

  assign unused_rot = rot;
  assign rot_eff    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!load && start) state_nxt = (shift_cnt != '0) ? SHIFT : DONE;
      SHIFT:   if (rem == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      sout  <= 1'b0;
      rem   <= '0;
      dir_r <= DIR_RIGHT;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            q <= din;
          end else if (start && shift_cnt != '0) begin
            rem   <= shift_cnt;
            dir_r <= dir;
          end
        end
        SHIFT: begin
          {sout, q} <= step_fn(q, dir_r, rot_eff, sin);
          rem       <= rem - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
